led_ctrl_conditioner: RTL

- Conditions the four raw `led_ctrl` pad inputs before they reach `led[7:4]` of the blink top level.
- Per channel:
  - synchronises the asynchronous input into the 12.5 MHz PLL domain `clk0_1`;
  - debounces it and emits one-cycle edge pulses;
  - optionally converts presses into a toggle state;
  - dims the result with a shared PWM duty.
- Sits directly upstream of the `led[7:4]` outputs; `stable` and the pulses are also ILA sample points.

---
 rtl/led_ctrl_conditioner.sv | 93 +++++++++
 1 files changed

// File: rtl/led_ctrl_conditioner.sv
// Conditions the raw led_ctrl pad inputs: synchronise, debounce with edge pulses,
// optional press-to-toggle, then PWM dimming ahead of the led[7:4] drivers.
module led_ctrl_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W           = 17,
  parameter int PWM_BITS        = 4
) (
  input  logic                clk0_1,
  input  logic                rst,
  input  logic [WIDTH-1:0]    led_ctrl_in,
  input  logic                toggle_mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [WIDTH-1:0]    stable,
  output logic [WIDTH-1:0]    rise_pulse,
  output logic [WIDTH-1:0]    fall_pulse,
  output logic [WIDTH-1:0]    led_out
);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  function automatic logic pwm_on(input logic [PWM_BITS-1:0] cnt_v,
                                  input logic [PWM_BITS-1:0] duty_v);
    return (duty_v == PWM_MAX) || (cnt_v < duty_v);
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0]                  sync_p0;
  logic [CNT_W-1:0]                  cnt_p1 [WIDTH];
  logic [WIDTH-1:0]                  tog;
  logic [PWM_BITS-1:0]               pcnt;
  logic [PWM_BITS-1:0]               duty_q;
  logic [WIDTH-1:0]                  src;
  logic                              on;

  // Stage p0: metastability chain into the clk0_1 domain
  always_ff @(posedge clk0_1) begin
    if (!rst) sync_chain <= '0;
    else      sync_chain <= {sync_chain[SYNC_STAGES-2:0], led_ctrl_in};
  end

  assign sync_p0 = sync_chain[SYNC_STAGES-1];

  // Stage p1: debounce; a level is accepted only after it differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk0_1) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_p1[i] <= '0;
      stable     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p0[i] == stable[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] == CNT_LAST) begin
          cnt_p1[i]     <= '0;
          stable[i]     <= sync_p0[i];
          rise_pulse[i] <= sync_p0[i];
          fall_pulse[i] <= ~sync_p0[i];
        end else begin
          cnt_p1[i] <= cnt_p1[i] + CNT_W'(1);
        end
      end
    end
  end

  // Toggle state and PWM timebase; duty only changes at a period boundary
  always_ff @(posedge clk0_1) begin
    if (!rst) begin
      tog    <= '0;
      pcnt   <= '0;
      duty_q <= '0;
    end else begin
      tog  <= tog ^ rise_pulse;
      pcnt <= pcnt + PWM_BITS'(1);
      if (pcnt == PWM_MAX) duty_q <= duty;
    end
  end

  assign src = toggle_mode ? tog : stable;
  assign on  = pwm_on(pcnt, duty_q);

  // Stage p2: registered, PWM-gated LED drive
  always_ff @(posedge clk0_1) begin
    if (!rst) led_out <= '0;
    else      led_out <= src & {WIDTH{on}};
  end

endmodule
